// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - set-time control: button debounce, hour/minute edit FSM, load strobes.
// Optional macro TSET_SEC_CLR_EN: also pulse nclr_sec_o during the commit cycle.
module time_set_ctrl #(
  parameter int DB_TICKS    = 4,
  parameter int HR_MAX_TENS = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [3:0] cur_min_ones_i,
  input  logic [2:0] cur_min_tens_i,
  input  logic [3:0] cur_hr_ones_i,
  input  logic [1:0] cur_hr_tens_i,
  output logic       run_en_o,
  output logic [3:0] ld_min_ones_o,
  output logic [2:0] ld_min_tens_o,
  output logic [3:0] ld_hr_ones_o,
  output logic [1:0] ld_hr_tens_o,
  output logic       nload_min_o,
  output logic       nload_hr_o,
  output logic       nclr_sec_o,
  output logic [1:0] set_state_o
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3} state_t;

  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_ff <= 2'b00;
    else         rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  // Index 0 is MODE, index 1 is INC.
  logic [1:0] sync1, sync2, stable, stable_q;
  logic [3:0] cnt [2];
  logic [1:0] ev;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync1    <= {btn_inc_i, btn_mode_i};
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (tick_i) begin
          if (sync2[i] != stable[i]) begin
            if (cnt[i] == 4'(DB_TICKS - 1)) begin
              stable[i] <= sync2[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end
  assign ev = stable & ~stable_q;

  state_t     state;
  logic [3:0] e_min_ones, e_hr_ones;
  logic [2:0] e_min_tens;
  logic [1:0] e_hr_tens;
  logic [3:0] nx_min_ones, nx_hr_ones;
  logic [2:0] nx_min_tens;
  logic [1:0] nx_hr_tens;

  // Out-of-range values (including glitched captures) wrap straight to 00.
  always_comb begin
    nx_hr_ones  = e_hr_ones + 4'd1;
    nx_hr_tens  = e_hr_tens;
    nx_min_ones = e_min_ones + 4'd1;
    nx_min_tens = e_min_tens;
    if (e_hr_tens > 2'(HR_MAX_TENS) || e_hr_ones > 4'd9 ||
        (e_hr_tens == 2'(HR_MAX_TENS) && e_hr_ones >= 4'd3)) begin
      nx_hr_ones = 4'd0;
      nx_hr_tens = 2'd0;
    end else if (e_hr_ones == 4'd9) begin
      nx_hr_ones = 4'd0;
      nx_hr_tens = e_hr_tens + 2'd1;
    end
    if (e_min_tens > 3'd5 || e_min_ones > 4'd9 || (e_min_tens == 3'd5 && e_min_ones == 4'd9)) begin
      nx_min_ones = 4'd0;
      nx_min_tens = 3'd0;
    end else if (e_min_ones == 4'd9) begin
      nx_min_ones = 4'd0;
      nx_min_tens = e_min_tens + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      run_en_o    <= 1'b1;
      nload_min_o <= 1'b1;
      nload_hr_o  <= 1'b1;
`ifdef TSET_SEC_CLR_EN
      nclr_sec_o  <= 1'b1;
`endif
      e_min_ones  <= '0;
      e_min_tens  <= '0;
      e_hr_ones   <= '0;
      e_hr_tens   <= '0;
    end else begin
      case (state)
        RUN: if (ev[0]) begin
          e_min_ones <= cur_min_ones_i;
          e_min_tens <= cur_min_tens_i;
          e_hr_ones  <= cur_hr_ones_i;
          e_hr_tens  <= cur_hr_tens_i;
          state      <= SET_HR;
          run_en_o   <= 1'b0;
        end
        SET_HR: if (ev[0]) begin
          state <= SET_MIN;
        end else if (ev[1]) begin
          e_hr_ones <= nx_hr_ones;
          e_hr_tens <= nx_hr_tens;
        end
        SET_MIN: if (ev[0]) begin
          state       <= COMMIT;
          nload_min_o <= 1'b0;
          nload_hr_o  <= 1'b0;
`ifdef TSET_SEC_CLR_EN
          nclr_sec_o  <= 1'b0;
`endif
        end else if (ev[1]) begin
          e_min_ones <= nx_min_ones;
          e_min_tens <= nx_min_tens;
        end
        default: begin
          state       <= RUN;
          run_en_o    <= 1'b1;
          nload_min_o <= 1'b1;
          nload_hr_o  <= 1'b1;
`ifdef TSET_SEC_CLR_EN
          nclr_sec_o  <= 1'b1;
`endif
        end
      endcase
    end
  end

`ifndef TSET_SEC_CLR_EN
  assign nclr_sec_o = 1'b1;
`endif

  assign set_state_o   = state;
  assign ld_min_ones_o = e_min_ones;
  assign ld_min_tens_o = e_min_tens;
  assign ld_hr_ones_o  = e_hr_ones;
  assign ld_hr_tens_o  = e_hr_tens;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed scoreboard bench for time_set_ctrl.
module tb_time_set_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       btn_mode_i = 1'b0;
  logic       btn_inc_i = 1'b0;
  logic [3:0] cur_min_ones_i = '0;
  logic [2:0] cur_min_tens_i = '0;
  logic [3:0] cur_hr_ones_i = '0;
  logic [1:0] cur_hr_tens_i = '0;
  logic       run_en_o;
  logic [3:0] ld_min_ones_o;
  logic [2:0] ld_min_tens_o;
  logic [3:0] ld_hr_ones_o;
  logic [1:0] ld_hr_tens_o;
  logic       nload_min_o;
  logic       nload_hr_o;
  logic       nclr_sec_o;
  logic [1:0] set_state_o;

  time_set_ctrl #(.DB_TICKS(4), .HR_MAX_TENS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i),
    .btn_mode_i(btn_mode_i), .btn_inc_i(btn_inc_i),
    .cur_min_ones_i(cur_min_ones_i), .cur_min_tens_i(cur_min_tens_i),
    .cur_hr_ones_i(cur_hr_ones_i), .cur_hr_tens_i(cur_hr_tens_i),
    .run_en_o(run_en_o),
    .ld_min_ones_o(ld_min_ones_o), .ld_min_tens_o(ld_min_tens_o),
    .ld_hr_ones_o(ld_hr_ones_o), .ld_hr_tens_o(ld_hr_tens_o),
    .nload_min_o(nload_min_o), .nload_hr_o(nload_hr_o),
    .nclr_sec_o(nclr_sec_o), .set_state_o(set_state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin : tick_gen
    forever begin
      repeat (3) @(negedge clk_i);
      tick_i = 1'b1;
      @(negedge clk_i);
      tick_i = 1'b0;
    end
  end

  // Strobe monitor: counts low cycles and captures the load values.
  int          nl_hr_cnt = 0;
  int          nl_min_cnt = 0;
  int          nclr_cnt = 0;
  logic [12:0] cap = '0;
  always @(negedge clk_i) begin
    if (!nload_hr_o) begin
      nl_hr_cnt = nl_hr_cnt + 1;
      cap = {ld_hr_tens_o, ld_hr_ones_o, ld_min_tens_o, ld_min_ones_o};
    end
    if (!nload_min_o) nl_min_cnt = nl_min_cnt + 1;
    if (!nclr_sec_o)  nclr_cnt = nclr_cnt + 1;
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [18:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [18:0] vec(input logic [1:0] st, input logic run,
                                      input logic [1:0] ht, input logic [3:0] ho,
                                      input logic [2:0] mt, input logic [3:0] mo);
    return {st, run, 3'b111, ht, ho, mt, mo};
  endfunction

  function automatic logic [18:0] obs();
    return {set_state_o, run_en_o, nload_min_o, nload_hr_o, nclr_sec_o,
            ld_hr_tens_o, ld_hr_ones_o, ld_min_tens_o, ld_min_ones_o};
  endfunction

  task automatic push(input string tag, input logic [18:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [18:0] act);
    logic [18:0] e;
    string       t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected none", act);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (act === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, act, e);
      end
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode_i = m;
    btn_inc_i  = i;
    repeat (30) @(negedge clk_i);
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    repeat (30) @(negedge clk_i);
  endtask

  task automatic set_cur(input logic [1:0] ht, input logic [3:0] ho,
                         input logic [2:0] mt, input logic [3:0] mo);
    cur_hr_tens_i  = ht;
    cur_hr_ones_i  = ho;
    cur_min_tens_i = mt;
    cur_min_ones_i = mo;
  endtask

  int base_hr, base_min, base_clr, exp_clr;

  initial begin
`ifdef TSET_SEC_CLR_EN
    exp_clr = 1;
`else
    exp_clr = 0;
`endif
    set_cur(2'd1, 4'd2, 3'd3, 4'd4);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    push("reset_state", vec(2'd0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0));
    check(obs());

    // Bounce shorter than the debounce window.
    btn_mode_i = 1'b1; repeat (6) @(negedge clk_i);
    btn_mode_i = 1'b0; repeat (4) @(negedge clk_i);
    btn_mode_i = 1'b1; repeat (6) @(negedge clk_i);
    btn_mode_i = 1'b0; repeat (30) @(negedge clk_i);
    push("bounce_ignored", vec(2'd0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0));
    check(obs());

    press(1'b1, 1'b0);
    push("enter_set_hr", vec(2'd1, 1'b0, 2'd1, 4'd2, 3'd3, 4'd4));
    check(obs());
    press(1'b0, 1'b1);
    push("inc_hr_12_13", vec(2'd1, 1'b0, 2'd1, 4'd3, 3'd3, 4'd4));
    check(obs());
    press(1'b1, 1'b0);
    push("enter_set_min", vec(2'd2, 1'b0, 2'd1, 4'd3, 3'd3, 4'd4));
    check(obs());
    press(1'b0, 1'b1);
    push("inc_min_34_35", vec(2'd2, 1'b0, 2'd1, 4'd3, 3'd3, 4'd5));
    check(obs());
    base_hr = nl_hr_cnt; base_min = nl_min_cnt; base_clr = nclr_cnt;
    press(1'b1, 1'b0);
    push("commit1_hr_cnt", 19'd1);   check(19'(nl_hr_cnt - base_hr));
    push("commit1_min_cnt", 19'd1);  check(19'(nl_min_cnt - base_min));
    push("commit1_clr_cnt", 19'(exp_clr)); check(19'(nclr_cnt - base_clr));
    push("commit1_ld", 19'({2'd1, 4'd3, 3'd3, 4'd5})); check(19'(cap));
    push("commit1_run", vec(2'd0, 1'b1, 2'd1, 4'd3, 3'd3, 4'd5));
    check(obs());

    // 22:58 through both wrap points.
    set_cur(2'd2, 4'd2, 3'd5, 4'd8);
    press(1'b1, 1'b0);
    push("cap_2258", vec(2'd1, 1'b0, 2'd2, 4'd2, 3'd5, 4'd8)); check(obs());
    press(1'b0, 1'b1);
    push("inc_hr_22_23", vec(2'd1, 1'b0, 2'd2, 4'd3, 3'd5, 4'd8)); check(obs());
    press(1'b0, 1'b1);
    push("inc_hr_23_00", vec(2'd1, 1'b0, 2'd0, 4'd0, 3'd5, 4'd8)); check(obs());
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    push("inc_min_58_59", vec(2'd2, 1'b0, 2'd0, 4'd0, 3'd5, 4'd9)); check(obs());
    press(1'b0, 1'b1);
    push("inc_min_59_00", vec(2'd2, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0)); check(obs());
    base_hr = nl_hr_cnt; base_min = nl_min_cnt; base_clr = nclr_cnt;
    cap = 13'h1fff;
    press(1'b1, 1'b0);
    push("commit2_hr_cnt", 19'd1);   check(19'(nl_hr_cnt - base_hr));
    push("commit2_min_cnt", 19'd1);  check(19'(nl_min_cnt - base_min));
    push("commit2_clr_cnt", 19'(exp_clr)); check(19'(nclr_cnt - base_clr));
    push("commit2_ld", 19'd0);       check(19'(cap));
    push("commit2_run", vec(2'd0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0)); check(obs());

    // 19 -> 20 carry, then simultaneous MODE+INC keeps hours.
    set_cur(2'd1, 4'd9, 3'd1, 4'd5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    push("inc_hr_19_20", vec(2'd1, 1'b0, 2'd2, 4'd0, 3'd1, 4'd5)); check(obs());
    press(1'b1, 1'b1);
    push("mode_inc_same", vec(2'd2, 1'b0, 2'd2, 4'd0, 3'd1, 4'd5)); check(obs());
    press(1'b0, 1'b1);
    push("inc_min_15_16", vec(2'd2, 1'b0, 2'd2, 4'd0, 3'd1, 4'd6)); check(obs());

    // Reset mid-edit abandons it.
    base_hr = nl_hr_cnt; base_min = nl_min_cnt;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    push("reset_mid_edit", vec(2'd0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0)); check(obs());
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    push("after_reset_state", vec(2'd0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0)); check(obs());
    push("no_load_on_reset", 19'd0);
    check(19'((nl_hr_cnt - base_hr) + (nl_min_cnt - base_min)));

    // Glitched hour 27 wraps on first INC.
    set_cur(2'd2, 4'd7, 3'd4, 4'd2);
    press(1'b1, 1'b0);
    push("cap_illegal_27", vec(2'd1, 1'b0, 2'd2, 4'd7, 3'd4, 4'd2)); check(obs());
    press(1'b0, 1'b1);
    push("inc_hr_27_00", vec(2'd1, 1'b0, 2'd0, 4'd0, 3'd4, 4'd2)); check(obs());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
